// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch -- RV32I instruction fetch stage
//
// Owns the program counter, drives the word address into a combinational
// instruction memory and captures the returned word with its PC into a
// one-entry fetch/decode register. That register is handed to decode over a
// valid/ready handshake. Execute may redirect the PC. The stage stops on an
// all-zero word (HALT) or on an illegal fetch address (TRAP).
//
// Parameters
//   RESET_PC        PC loaded on reset
//   IMEM_WORDS      instruction memory depth in words
//
// Ports
//   clk             system clock, rising edge
//   reset           synchronous active-high reset
//   imem_addr       byte address into instruction memory (copy of pc)
//   imem_data       instruction word for imem_addr (combinational)
//   redirect_valid  execute requests a PC change
//   redirect_target new PC, bit 0 ignored
//   out_valid       fetch/decode register holds an instruction
//   out_ready       decode accepts the entry this cycle
//   out_instr       captured instruction word
//   out_pc          PC of out_instr
//   out_pc_plus4    out_pc + 4
//   halted          stopped on an all-zero word
//   trap            stopped on an illegal fetch
//   trap_cause      1 = misaligned target, 2 = out of range, 0 = none
//   trap_pc         offending address
//   fetch_count     instructions captured since reset (wraps)
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        halted,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] trap_pc,
    output logic [15:0] fetch_count
);

    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_TRAP  = 2'd3;

    // First byte address past the end of instruction memory.
    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [1:0]  state_reg,       state_next;
    logic [31:0] pc_reg,          pc_next;
    logic        out_valid_reg,   out_valid_next;
    logic [31:0] out_instr_reg,   out_instr_next;
    logic [31:0] out_pc_reg,      out_pc_next;
    logic [1:0]  trap_cause_reg,  trap_cause_next;
    logic [31:0] trap_pc_reg,     trap_pc_next;
    logic [15:0] fetch_count_reg, fetch_count_next;

    logic        advance;
    logic [31:0] redirect_pc;

    // The register may be refilled when it is empty or is being drained.
    assign advance     = !out_valid_reg || out_ready;
    // jalr-style targets can carry bit 0; it is simply dropped.
    assign redirect_pc = redirect_target & ~32'h0000_0001;

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        out_valid_next   = out_valid_reg;
        out_instr_next   = out_instr_reg;
        out_pc_next      = out_pc_reg;
        trap_cause_next  = trap_cause_reg;
        trap_pc_next     = trap_pc_reg;
        fetch_count_next = fetch_count_reg;

        case (state_reg)
            S_START: begin
                // One idle cycle so imem_data reflects the reset PC.
                state_next = S_RUN;
            end

            S_RUN, S_HALT: begin
                if (redirect_valid) begin
                    // Any pending entry is on the wrong path: flush it,
                    // even if decode is stalling it.
                    out_valid_next = 1'b0;
                    if (redirect_pc[1]) begin
                        // pc is left alone so a misaligned address never
                        // reaches imem_addr.
                        state_next      = S_TRAP;
                        trap_cause_next = 2'd1;
                        trap_pc_next    = redirect_pc;
                    end else begin
                        state_next = S_RUN;
                        pc_next    = redirect_pc;
                    end
                end else if (state_reg == S_HALT) begin
                    if (out_ready) begin
                        out_valid_next = 1'b0;
                    end
                end else if (advance) begin
                    if (pc_reg >= IMEM_LIMIT) begin
                        state_next      = S_TRAP;
                        trap_cause_next = 2'd2;
                        trap_pc_next    = pc_reg;
                        out_valid_next  = 1'b0;
                    end else if (imem_data == 32'h0) begin
                        state_next     = S_HALT;
                        out_valid_next = 1'b0;
                    end else begin
                        out_valid_next   = 1'b1;
                        out_instr_next   = imem_data;
                        out_pc_next      = pc_reg;
                        pc_next          = pc_reg + 32'd4;
                        fetch_count_next = fetch_count_reg + 16'd1;
                    end
                end
            end

            default: begin
                // TRAP: redirects ignored, only the pending entry drains.
                if (out_ready) begin
                    out_valid_next = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_START;
            pc_reg          <= RESET_PC;
            out_valid_reg   <= 1'b0;
            out_instr_reg   <= NOP;
            out_pc_reg      <= 32'h0;
            trap_cause_reg  <= 2'd0;
            trap_pc_reg     <= 32'h0;
            fetch_count_reg <= 16'h0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            out_valid_reg   <= out_valid_next;
            out_instr_reg   <= out_instr_next;
            out_pc_reg      <= out_pc_next;
            trap_cause_reg  <= trap_cause_next;
            trap_pc_reg     <= trap_pc_next;
            fetch_count_reg <= fetch_count_next;
        end
    end

    assign imem_addr    = pc_reg;
    assign out_valid    = out_valid_reg;
    assign out_instr    = out_instr_reg;
    assign out_pc       = out_pc_reg;
    assign out_pc_plus4 = out_pc_reg + 32'd4;
    assign halted       = (state_reg == S_HALT);
    assign trap         = (state_reg == S_TRAP);
    assign trap_cause   = trap_cause_reg;
    assign trap_pc      = trap_pc_reg;
    assign fetch_count  = fetch_count_reg;

endmodule
